// File: rtl/l1_rd_port_tagged_pkg.sv
// Purpose: shared width helpers for the L1 read-port family.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package l1_rd_pkg;

  // Index width for n items; never returns 0 so single-entry vectors still get a bit.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width needed to hold a count from 0 to n inclusive.
  function automatic int cnt_width_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/l1_rd_port_tagged_if.sv
// Purpose: AFU request channel plus BRAM address branch of one L1 read port.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request (i_rd_*) and address (o_addr_*) channels.
//   master: AFU/consumer side; slave: the read port.
interface l1_rd_port_tagged_if #(
  parameter int nstrms_width = 6,
  parameter int tag_width    = 4,
  parameter int ptr_width    = 4
);
  logic                    i_rd_v;
  logic                    i_rd_r;
  logic [nstrms_width-1:0] i_rd_sid;
  logic [tag_width-1:0]    i_rd_tag;

  logic                    o_addr_v;
  logic                    o_addr_r;
  logic [ptr_width-1:0]    o_addr_ptr;
  logic [nstrms_width-1:0] o_addr_sid;
  logic [tag_width-1:0]    o_addr_tag;
  logic                    o_addr_discard;

  modport master (
    output i_rd_v, i_rd_sid, i_rd_tag, o_addr_r,
    input  i_rd_r, o_addr_v, o_addr_ptr, o_addr_sid, o_addr_tag, o_addr_discard
  );

  modport slave (
    input  i_rd_v, i_rd_sid, i_rd_tag, o_addr_r,
    output i_rd_r, o_addr_v, o_addr_ptr, o_addr_sid, o_addr_tag, o_addr_discard
  );
endinterface

// File: rtl/base_cenc.sv
// Purpose: population count of din (number of set bits).
// Latency: combinational.
// Backpressure: none.
//   din: input vector; dout: number of ones in din.
module base_cenc #(
  parameter int width  = 8,
  parameter int owidth = $clog2(width + 1)
) (
  input  logic [width-1:0]  din,
  output logic [owidth-1:0] dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < width; i++) begin
      dout = dout + owidth'(din[i]);
    end
  end
endmodule

// File: rtl/base_decode_le.sv
// Purpose: binary to one-hot decoder with enable; codes beyond dec_width decode to zero.
// Latency: combinational.
// Backpressure: none.
//   en: enable; din: binary code; dout: one-hot (all zero when en=0).
module base_decode_le #(
  parameter int enc_width = 6,
  parameter int dec_width = 1 << enc_width
) (
  input  logic                 en,
  input  logic [enc_width-1:0] din,
  output logic [dec_width-1:0] dout
);
  always_comb begin
    dout = '0;
    for (int i = 0; i < dec_width; i++) begin
      dout[i] = en & (din == enc_width'(i));
    end
  end
endmodule

// File: rtl/l1_rd_port_tagged_fork.sv
// Purpose: 1-to-2 valid/ready fork; each branch may be accepted in a different cycle.
// Latency: combinational valids; done flags remember branches already accepted.
// Backpressure: input retires only once both branches are done (branch 1 skippable).
//   i_v/o_retire: upstream valid and its completion; i_skip1: branch 1 needs no handshake;
//   o0_*/o1_*: branch handshakes; o_started: some branch accepted in an earlier cycle.
module l1_rd_fork (
  input  logic clk,
  input  logic reset,
  input  logic i_v,
  input  logic i_skip1,
  output logic o0_v,
  input  logic o0_r,
  output logic o1_v,
  input  logic o1_r,
  output logic o0_fire,
  output logic o1_fire,
  output logic o_started,
  output logic o_retire
);
  logic done0_q, done0_d;
  logic done1_q, done1_d;

  always_comb begin
    o0_v      = i_v & ~done0_q;
    o1_v      = i_v & ~i_skip1 & ~done1_q;
    o0_fire   = o0_v & o0_r;
    o1_fire   = o1_v & o1_r;
    o_retire  = i_v & (done0_q | o0_fire) & (i_skip1 | done1_q | o1_fire);
    o_started = done0_q | done1_q;
    // Flags clear on retire so the next item starts with both branches open.
    done0_d   = o_retire ? 1'b0 : (done0_q | o0_fire);
    done1_d   = o_retire ? 1'b0 : (done1_q | o1_fire);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end
endmodule

// File: rtl/l1_rd_port_tagged.sv
// Purpose: L1 read port; registers {sid,tag}, computes the L1 pointer and forks it into
//   the BRAM address branch and the one-hot pointer-update branch; ended streams are
//   returned in order flagged o_addr_discard and counted in o_disc_cnt (saturating).
// Latency: 1 cycle from request acceptance to o_addr_v.
// Backpressure: i_rd_r = ~s1_v | retire, so a new request loads the cycle the old retires.
//   Ports: clk/reset, per-stream status (i_rst_end, i_l1_end, i_single_v, i_ptrs),
//   peer activity (i_rd_acts, i_rd_sids), o_rd_act, o_req_v/o_req_r, o_disc_cnt, rd_if.
module l1_rd_port_tagged
  import l1_rd_pkg::*;
#(
  parameter int nstrms       = 64,
  parameter int nstrms_width = width_of(nstrms),
  parameter int nports       = 8,
  parameter int portid       = 0,
  parameter int ptr_width    = 4,
  parameter int cl_size      = 8,
  parameter int clofs_width  = width_of(cl_size),
  parameter int tag_width    = 4,
  parameter int cnt_width    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [nstrms-1:0]             i_rst_end,
  input  logic [nstrms-1:0]             i_l1_end,
  input  logic [nstrms-1:0]             i_single_v,
  input  logic [nports-1:0]             i_rd_acts,
  input  logic [nports*nstrms_width-1:0] i_rd_sids,
  output logic                          o_rd_act,
  input  logic [nstrms*ptr_width-1:0]   i_ptrs,
  output logic [nstrms-1:0]             o_req_v,
  input  logic [nstrms-1:0]             o_req_r,
  output logic [cnt_width-1:0]          o_disc_cnt,
  l1_rd_port_tagged_if.slave            rd_if
);
  localparam int inc_width = cnt_width_of(nports);

  logic                    s1_v_q, s1_v_d;
  logic [nstrms_width-1:0] s1_sid_q, s1_sid_d;
  logic [tag_width-1:0]    s1_tag_q, s1_tag_d;
  logic                    disc_q, disc_d;
  logic [cnt_width-1:0]    disc_cnt_q, disc_cnt_d;

  logic                    rd_rdy, s1_load, s1_retire, started;
  logic                    addr_v, addr_fire, req_v, req_rdy, req_fire;
  logic                    sid_oob, disc_c, disc;
  logic [nports-1:0]       hits;
  logic [inc_width-1:0]    inc;
  logic [ptr_width-1:0]    ptr_base, ptr_calc;
  logic [nstrms-1:0]       sid_oh;

  // Only lower-numbered ports that consumed a slot on our stream push our pointer.
  always_comb begin
    hits = '0;
    for (int i = 0; i < nports; i++) begin
      hits[i] = (i < portid) && i_rd_acts[i] &&
                (i_rd_sids[i*nstrms_width +: nstrms_width] == s1_sid_q);
    end
  end

  base_cenc #(.width(nports), .owidth(inc_width)) u_cenc (
    .din  (hits),
    .dout (inc)
  );

  base_decode_le #(.enc_width(nstrms_width), .dec_width(nstrms)) u_dec (
    .en   (1'b1),
    .din  (s1_sid_q),
    .dout (sid_oh)
  );

  always_comb begin
    sid_oob  = (int'(s1_sid_q) >= nstrms);
    ptr_base = i_ptrs[int'(s1_sid_q)*ptr_width +: ptr_width];
    ptr_calc = ptr_base + ptr_width'(inc);   // wraps modulo 2^ptr_width
    // Crossing into the next cacheline of a single-line stream that L2 has ended
    // has nothing left to read.
    disc_c   = sid_oob | i_l1_end[s1_sid_q] |
               (i_rst_end[s1_sid_q] & i_single_v[s1_sid_q] & ptr_calc[clofs_width]);
    // Once one branch has gone out the decision is frozen so both branches agree.
    disc     = started ? disc_q : disc_c;
    req_rdy  = |(sid_oh & o_req_r);
  end

  l1_rd_fork u_fork (
    .clk       (clk),
    .reset     (reset),
    .i_v       (s1_v_q),
    .i_skip1   (disc),
    .o0_v      (addr_v),
    .o0_r      (rd_if.o_addr_r),
    .o1_v      (req_v),
    .o1_r      (req_rdy),
    .o0_fire   (addr_fire),
    .o1_fire   (req_fire),
    .o_started (started),
    .o_retire  (s1_retire)
  );

  always_comb begin
    rd_rdy     = ~s1_v_q | s1_retire;
    s1_load    = rd_if.i_rd_v & rd_rdy;
    s1_v_d     = s1_load ? 1'b1 : (s1_retire ? 1'b0 : s1_v_q);
    s1_sid_d   = s1_load ? rd_if.i_rd_sid : s1_sid_q;
    s1_tag_d   = s1_load ? rd_if.i_rd_tag : s1_tag_q;

    disc_d = disc_q;
    if (s1_retire) begin
      disc_d = 1'b0;
    end else if (!started && (addr_fire || req_fire)) begin
      disc_d = disc_c;
    end

    disc_cnt_d = disc_cnt_q;
    if (s1_retire && disc && !(&disc_cnt_q)) begin
      disc_cnt_d = disc_cnt_q + cnt_width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q     <= 1'b0;
      s1_sid_q   <= '0;
      s1_tag_q   <= '0;
      disc_q     <= 1'b0;
      disc_cnt_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_sid_q   <= s1_sid_d;
      s1_tag_q   <= s1_tag_d;
      disc_q     <= disc_d;
      disc_cnt_q <= disc_cnt_d;
    end
  end

  assign rd_if.i_rd_r         = rd_rdy;
  assign rd_if.o_addr_v       = addr_v;
  assign rd_if.o_addr_ptr     = disc ? '0 : ptr_calc;
  assign rd_if.o_addr_sid     = s1_sid_q;
  assign rd_if.o_addr_tag     = s1_tag_q;
  assign rd_if.o_addr_discard = disc;
  assign o_req_v              = sid_oh & {nstrms{req_v}};
  assign o_rd_act             = s1_retire & ~disc;   // discarded reads never advance offsets
  assign o_disc_cnt           = disc_cnt_q;
endmodule

// File: tb/tb_l1_rd_port_tagged.sv
module tb_l1_rd_port_tagged;
  localparam int NS = 64;
  localparam int SW = 6;
  localparam int NP = 8;
  localparam int PW = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NS-1:0]     rst_end, l1_end, single_v, req_r;
  logic [NP-1:0]     rd_acts;
  logic [NP*SW-1:0]  rd_sids;
  logic [NS*PW-1:0]  ptrs;
  logic              rd_act0, rd_act1, rd_act2;
  logic [NS-1:0]     req_v0, req_v1, req_v2;
  logic [1:0]        cnt0;
  logic [15:0]       cnt1, cnt2;
  int total = 0;
  int bad = 0;

  l1_rd_port_tagged_if #(.nstrms_width(SW), .tag_width(TW), .ptr_width(PW)) if0 ();
  l1_rd_port_tagged_if #(.nstrms_width(SW), .tag_width(TW), .ptr_width(PW)) if1 ();
  l1_rd_port_tagged_if #(.nstrms_width(SW), .tag_width(TW), .ptr_width(PW)) if2 ();

  l1_rd_port_tagged #(.portid(0), .cnt_width(2)) u_p0 (
    .clk(clk), .reset(reset), .i_rst_end(rst_end), .i_l1_end(l1_end), .i_single_v(single_v),
    .i_rd_acts(rd_acts), .i_rd_sids(rd_sids), .o_rd_act(rd_act0), .i_ptrs(ptrs),
    .o_req_v(req_v0), .o_req_r(req_r), .o_disc_cnt(cnt0), .rd_if(if0.slave));
  l1_rd_port_tagged #(.portid(1)) u_p1 (
    .clk(clk), .reset(reset), .i_rst_end(rst_end), .i_l1_end(l1_end), .i_single_v(single_v),
    .i_rd_acts(rd_acts), .i_rd_sids(rd_sids), .o_rd_act(rd_act1), .i_ptrs(ptrs),
    .o_req_v(req_v1), .o_req_r(req_r), .o_disc_cnt(cnt1), .rd_if(if1.slave));
  l1_rd_port_tagged #(.portid(2)) u_p2 (
    .clk(clk), .reset(reset), .i_rst_end(rst_end), .i_l1_end(l1_end), .i_single_v(single_v),
    .i_rd_acts(rd_acts), .i_rd_sids(rd_sids), .o_rd_act(rd_act2), .i_ptrs(ptrs),
    .o_req_v(req_v2), .o_req_r(req_r), .o_disc_cnt(cnt2), .rd_if(if2.slave));

  // One-cycle request on port p; returns #1 after the loading edge with all valids low.
  task automatic issue(input int p, input int sid, input int tag);
    @(posedge clk); #1;
    case (p)
      0: begin if0.i_rd_v = 1'b1; if0.i_rd_sid = SW'(sid); if0.i_rd_tag = TW'(tag); end
      1: begin if1.i_rd_v = 1'b1; if1.i_rd_sid = SW'(sid); if1.i_rd_tag = TW'(tag); end
      default: begin if2.i_rd_v = 1'b1; if2.i_rd_sid = SW'(sid); if2.i_rd_tag = TW'(tag); end
    endcase
    @(posedge clk); #1;
    if0.i_rd_v = 1'b0; if1.i_rd_v = 1'b0; if2.i_rd_v = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (if0.o_addr_v !== 1'b0) begin bad++; $display("FAIL rst_addr_v got=%0b exp=0", if0.o_addr_v); end
    total++; if (req_v0 !== '0) begin bad++; $display("FAIL rst_req_v got=%0h exp=0", req_v0); end
    total++; if (rd_act0 !== 1'b0) begin bad++; $display("FAIL rst_rd_act got=%0b exp=0", rd_act0); end
    total++; if (cnt0 !== 2'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", cnt0); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (if0.i_rd_r !== 1'b1 || if1.i_rd_r !== 1'b1 || if2.i_rd_r !== 1'b1) begin
      bad++; $display("FAIL rst_rd_r got=%0b%0b%0b exp=111", if0.i_rd_r, if1.i_rd_r, if2.i_rd_r); end
  endtask

  task automatic test_basic();
    ptrs[5*PW +: PW] = 4'd3;
    issue(0, 5, 10);
    @(negedge clk);
    total++; if (if0.o_addr_v !== 1'b1) begin bad++; $display("FAIL basic_addr_v got=%0b exp=1", if0.o_addr_v); end
    total++; if (if0.o_addr_ptr !== 4'd3) begin bad++; $display("FAIL basic_ptr got=%0d exp=3", if0.o_addr_ptr); end
    total++; if (if0.o_addr_sid !== 6'd5 || if0.o_addr_tag !== 4'hA) begin
      bad++; $display("FAIL basic_sid_tag got=%0d/%0h exp=5/a", if0.o_addr_sid, if0.o_addr_tag); end
    total++; if (if0.o_addr_discard !== 1'b0) begin bad++; $display("FAIL basic_disc got=%0b exp=0", if0.o_addr_discard); end
    total++; if (req_v0 !== (64'd1 << 5)) begin bad++; $display("FAIL basic_req_v got=%0h exp=20", req_v0); end
    total++; if (rd_act0 !== 1'b1) begin bad++; $display("FAIL basic_rd_act got=%0b exp=1", rd_act0); end
    @(negedge clk);
    total++; if (if0.o_addr_v !== 1'b0 || req_v0 !== '0) begin
      bad++; $display("FAIL basic_retired got=%0b/%0h exp=0/0", if0.o_addr_v, req_v0); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    if0.i_rd_v = 1'b1; if0.i_rd_sid = 6'd5; if0.i_rd_tag = 4'd1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 4) if0.i_rd_v = 1'b0;
      else if0.i_rd_tag = TW'(k + 1);
      @(negedge clk);
      total++; if (if0.o_addr_tag !== TW'(k) || rd_act0 !== 1'b1 || if0.i_rd_r !== 1'b1) begin
        bad++; $display("FAIL b2b_%0d got tag=%0d act=%0b rdy=%0b exp tag=%0d act=1 rdy=1",
                        k, if0.o_addr_tag, rd_act0, if0.i_rd_r, k); end
    end
    @(negedge clk);
    total++; if (if0.o_addr_v !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b exp=0", if0.o_addr_v); end
  endtask

  task automatic test_offset();
    rd_acts = 8'b0000_0011;
    rd_sids[0*SW +: SW] = 6'd5;
    rd_sids[1*SW +: SW] = 6'd5;
    ptrs[5*PW +: PW] = 4'd6;
    issue(2, 5, 1);
    @(negedge clk);
    total++; if (if2.o_addr_ptr !== 4'd8 || if2.o_addr_discard !== 1'b0) begin
      bad++; $display("FAIL off_two_hits got=%0d/%0b exp=8/0", if2.o_addr_ptr, if2.o_addr_discard); end
    total++; if (req_v2 !== (64'd1 << 5) || rd_act2 !== 1'b1) begin
      bad++; $display("FAIL off_req got=%0h/%0b exp=20/1", req_v2, rd_act2); end
    rd_sids[1*SW +: SW] = 6'd9;
    issue(2, 5, 2);
    @(negedge clk);
    total++; if (if2.o_addr_ptr !== 4'd7) begin bad++; $display("FAIL off_one_hit got=%0d exp=7", if2.o_addr_ptr); end
    // Ports 2..7 also active on sid 5 but must not count for port 2.
    rd_acts = 8'hFF;
    for (int i = 0; i < NP; i++) rd_sids[i*SW +: SW] = 6'd5;
    ptrs[5*PW +: PW] = 4'd15;
    issue(2, 5, 3);
    @(negedge clk);
    total++; if (if2.o_addr_ptr !== 4'd1) begin bad++; $display("FAIL off_wrap got=%0d exp=1", if2.o_addr_ptr); end
    rd_acts = '0;
    rd_sids = '0;
    ptrs[5*PW +: PW] = 4'd3;
  endtask

  task automatic test_discard_l1_end();
    l1_end[7] = 1'b1;
    ptrs[7*PW +: PW] = 4'd2;
    issue(0, 7, 3);
    @(negedge clk);
    total++; if (if0.o_addr_v !== 1'b1 || if0.o_addr_discard !== 1'b1) begin
      bad++; $display("FAIL l1e_flag got=%0b/%0b exp=1/1", if0.o_addr_v, if0.o_addr_discard); end
    total++; if (if0.o_addr_ptr !== 4'd0) begin bad++; $display("FAIL l1e_ptr got=%0d exp=0", if0.o_addr_ptr); end
    total++; if (req_v0 !== '0 || rd_act0 !== 1'b0) begin
      bad++; $display("FAIL l1e_noreq got=%0h/%0b exp=0/0", req_v0, rd_act0); end
    total++; if (cnt0 !== 2'd0 || if0.i_rd_r !== 1'b1) begin
      bad++; $display("FAIL l1e_pre got cnt=%0d rdy=%0b exp 0/1", cnt0, if0.i_rd_r); end
    @(negedge clk);
    total++; if (cnt0 !== 2'd1) begin bad++; $display("FAIL l1e_cnt got=%0d exp=1", cnt0); end
    l1_end[7] = 1'b0;
  endtask

  task automatic test_rst_end();
    rst_end[3] = 1'b1;
    single_v[3] = 1'b1;
    ptrs[3*PW +: PW] = 4'd7;
    rd_acts = 8'b0000_0001;
    rd_sids[0*SW +: SW] = 6'd3;
    issue(1, 3, 5);
    @(negedge clk);
    total++; if (if1.o_addr_v !== 1'b1 || if1.o_addr_discard !== 1'b1 || if1.o_addr_ptr !== 4'd0) begin
      bad++; $display("FAIL rse_disc got v=%0b d=%0b p=%0d exp 1/1/0", if1.o_addr_v, if1.o_addr_discard, if1.o_addr_ptr); end
    total++; if (req_v1 !== '0 || rd_act1 !== 1'b0) begin
      bad++; $display("FAIL rse_noreq got=%0h/%0b exp=0/0", req_v1, rd_act1); end
    @(negedge clk);
    total++; if (cnt1 !== 16'd1) begin bad++; $display("FAIL rse_cnt got=%0d exp=1", cnt1); end
    rd_acts = '0;
    issue(1, 3, 6);
    @(negedge clk);
    total++; if (if1.o_addr_discard !== 1'b0 || if1.o_addr_ptr !== 4'd7) begin
      bad++; $display("FAIL rse_normal got d=%0b p=%0d exp 0/7", if1.o_addr_discard, if1.o_addr_ptr); end
    total++; if (req_v1 !== (64'd1 << 3) || rd_act1 !== 1'b1) begin
      bad++; $display("FAIL rse_req got=%0h/%0b exp=8/1", req_v1, rd_act1); end
    @(negedge clk);
    total++; if (cnt1 !== 16'd1) begin bad++; $display("FAIL rse_cnt_hold got=%0d exp=1", cnt1); end
    rst_end[3] = 1'b0;
    single_v[3] = 1'b0;
    rd_sids = '0;
  endtask

  task automatic test_split_accept();
    int fires;
    fires = 0;
    req_r = '0;
    ptrs[9*PW +: PW] = 4'd4;
    issue(0, 9, 7);
    @(negedge clk);
    if (if0.o_addr_v && if0.o_addr_r) fires++;
    total++; if (if0.o_addr_v !== 1'b1 || req_v0 !== (64'd1 << 9) || if0.o_addr_discard !== 1'b0) begin
      bad++; $display("FAIL split_c1 got v=%0b req=%0h d=%0b exp 1/200/0", if0.o_addr_v, req_v0, if0.o_addr_discard); end
    total++; if (if0.i_rd_r !== 1'b0 || rd_act0 !== 1'b0) begin
      bad++; $display("FAIL split_c1_rdy got=%0b/%0b exp=0/0", if0.i_rd_r, rd_act0); end
    @(posedge clk); #1;
    l1_end[9] = 1'b1;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      if (if0.o_addr_v && if0.o_addr_r) fires++;
      total++; if (if0.o_addr_v !== 1'b0 || req_v0 !== (64'd1 << 9) || if0.o_addr_discard !== 1'b0 || if0.i_rd_r !== 1'b0) begin
        bad++; $display("FAIL split_c%0d got v=%0b req=%0h d=%0b rdy=%0b exp 0/200/0/0",
                        c, if0.o_addr_v, req_v0, if0.o_addr_discard, if0.i_rd_r); end
      @(posedge clk); #1;
    end
    req_r = '1;
    @(negedge clk);
    if (if0.o_addr_v && if0.o_addr_r) fires++;
    total++; if (req_v0 !== (64'd1 << 9) || rd_act0 !== 1'b1 || if0.i_rd_r !== 1'b1) begin
      bad++; $display("FAIL split_c4 got req=%0h act=%0b rdy=%0b exp 200/1/1", req_v0, rd_act0, if0.i_rd_r); end
    @(negedge clk);
    total++; if (fires !== 1) begin bad++; $display("FAIL split_addr_once got=%0d exp=1", fires); end
    total++; if (if0.o_addr_v !== 1'b0 || cnt0 !== 2'd1) begin
      bad++; $display("FAIL split_after got v=%0b cnt=%0d exp 0/1", if0.o_addr_v, cnt0); end
    l1_end[9] = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_r = '0;
    issue(0, 5, 2);
    @(negedge clk);
    total++; if (req_v0 !== (64'd1 << 5)) begin bad++; $display("FAIL rmid_pending got=%0h exp=20", req_v0); end
    reset = 1'b0;
    #1;
    total++; if (if0.o_addr_v !== 1'b0 || req_v0 !== '0 || cnt0 !== 2'd0 || if0.i_rd_r !== 1'b1) begin
      bad++; $display("FAIL rmid_cleared got v=%0b req=%0h cnt=%0d rdy=%0b exp 0/0/0/1",
                      if0.o_addr_v, req_v0, cnt0, if0.i_rd_r); end
    @(negedge clk);
    reset = 1'b1;
    req_r = '1;
    issue(0, 5, 4);
    @(negedge clk);
    total++; if (if0.o_addr_ptr !== 4'd3 || if0.o_addr_tag !== 4'd4 || req_v0 !== (64'd1 << 5) || rd_act0 !== 1'b1) begin
      bad++; $display("FAIL rmid_fresh got p=%0d t=%0d req=%0h act=%0b exp 3/4/20/1",
                      if0.o_addr_ptr, if0.o_addr_tag, req_v0, rd_act0); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    l1_end[7] = 1'b1;
    @(posedge clk); #1;
    if0.i_rd_v = 1'b1; if0.i_rd_sid = 6'd7; if0.i_rd_tag = 4'd0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 4) if0.i_rd_v = 1'b0;
      @(negedge clk);
      total++; if (cnt0 !== exp_cnt[k] || if0.o_addr_discard !== 1'b1 || rd_act0 !== 1'b0) begin
        bad++; $display("FAIL sat_%0d got cnt=%0d d=%0b act=%0b exp cnt=%0d d=1 act=0",
                        k, cnt0, if0.o_addr_discard, rd_act0, exp_cnt[k]); end
    end
    @(negedge clk);
    total++; if (cnt0 !== 2'd3) begin bad++; $display("FAIL sat_final got=%0d exp=3", cnt0); end
    l1_end[7] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    rst_end = '0; l1_end = '0; single_v = '0; req_r = '1;
    rd_acts = '0; rd_sids = '0; ptrs = '0;
    if0.i_rd_v = 1'b0; if0.i_rd_sid = '0; if0.i_rd_tag = '0; if0.o_addr_r = 1'b1;
    if1.i_rd_v = 1'b0; if1.i_rd_sid = '0; if1.i_rd_tag = '0; if1.o_addr_r = 1'b1;
    if2.i_rd_v = 1'b0; if2.i_rd_sid = '0; if2.i_rd_tag = '0; if2.o_addr_r = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_offset();
    test_discard_l1_end();
    test_rst_end();
    test_split_accept();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l1_rd_port_tagged.md
Name: l1_rd_port_tagged

Overview:
- Next-generation L1 read port for the multi-stream buffer. One instance per read port, indexed by portid.
- Registers an AFU read request (stream id plus tag) and computes the L1 BRAM pointer, adding one for each lower-numbered port reading the same stream this cycle.
- Forks the request into two branches: the BRAM address branch and the one-hot global pointer-update branch. The branches may be accepted in different cycles.
- New behaviour: a request for an ended or out-of-bounds stream is no longer silently dropped. It is returned in order with o_addr_discard=1, and a saturating discard counter counts these events.

Parameters:
- nstrms, 64, number of streams
- nstrms_width, $clog2(nstrms), stream id width
- nports, 8, number of read ports
- portid, 0, index of this port; 0 is highest priority
- ptr_width, 4, L1 pointer width
- cl_size, 8, reads per cacheline; must be >= nports
- clofs_width, $clog2(cl_size), cacheline offset width
- tag_width, 4, AFU request tag width
- cnt_width, 16, discard counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- i_rst_end  in  nstrms  L2 stream ended, per stream
- i_l1_end  in  nstrms  L1 stream ended, per stream
- i_single_v  in  nstrms  only one valid L1 line, per stream
- i_rd_v  in  1  request valid
- i_rd_r  out  1  request ready
- i_rd_sid  in  nstrms_width  requested stream id
- i_rd_tag  in  tag_width  AFU tag
- i_rd_acts  in  nports  o_rd_act of all ports
- i_rd_sids  in  nports*nstrms_width  o_addr_sid of all ports
- o_rd_act  out  1  this port consumed a pointer slot this cycle
- i_ptrs  in  nstrms*ptr_width  current pointer per stream
- o_addr_v  out  1  address branch valid
- o_addr_r  in  1  address branch ready
- o_addr_ptr  out  ptr_width  computed L1 pointer
- o_addr_sid  out  nstrms_width  stream id
- o_addr_tag  out  tag_width  tag passed through
- o_addr_discard  out  1  request discarded; no BRAM read
- o_req_v  out  nstrms  one-hot pointer-update valid
- o_req_r  in  nstrms  per-stream pointer-update ready
- o_disc_cnt  out  cnt_width  saturating discard count

Behaviour:
- Stage s1 is a single register holding {s1_v, sid, tag}.
  - Load condition: i_rd_v & i_rd_r.
  - i_rd_r = ~s1_v | s1_retire. This gives full throughput and one cycle of latency from acceptance to o_addr_v.
- Offset: inc = count of i in [0, portid) with i_rd_acts[i] & (i_rd_sids[i] == s1_sid).
  - For portid=0, inc=0.
  - ptr_calc = i_ptrs[s1_sid] + inc, computed modulo 2^ptr_width (wraps, no carry out).
- Discard condition: disc_c = i_l1_end[sid] | (i_rst_end[sid] & i_single_v[sid] & ptr_calc[clofs_width]).
  - disc = disc_c until the first branch is accepted. From then on disc = disc_q, a copy latched at that first acceptance, held until retire.
- Done flags addr_done and req_done are cleared on reset and on retire.
- Address branch:
  - o_addr_v = s1_v & ~addr_done.
  - o_addr_ptr = disc ? 0 : ptr_calc.
  - o_addr_sid and o_addr_tag reflect the s1 register.
  - o_addr_discard = disc.
- Update branch:
  - o_req_v = onehot(sid) when s1_v & ~disc & ~req_done; otherwise all zero.
  - req_fire = |(o_req_v & o_req_r).
  - When disc=1 the update branch counts as complete.
- Completion and activity:
  - s1_retire = s1_v & (addr_done | addr_fire) & (disc | req_done | req_fire).
  - o_rd_act = s1_retire & ~disc. A discarded read never advances any offset.
- Counter: o_disc_cnt increments on s1_retire & disc and saturates at all-ones.
- Reset: all of the following are 0: s1_v, both done flags, disc_q, o_disc_cnt, o_addr_v, o_req_v, o_rd_act. i_rd_r = 1 after release.
- Combinational path order: port k depends only on the o_rd_act of ports below k. No loops are allowed.
- i_l1_end rising while a request is half-accepted has no effect; disc stays at its latched value.
- Back-to-back requests: a new request is accepted in the same cycle the current one retires.

Decomposition:
- Package l1_rd_pkg holds no typedefs beyond what is needed. The width helper functions live in the package.
- Sub-module l1_rd_fork: a 1-to-2 valid/ready fork with per-branch done flags, a "skip branch 1" input (driven by disc), and a retire output. It is reusable by future L1 ports.
- The pop-count of hits uses the existing base_cenc; the stream-id decode uses the existing base_decode_le.

Test Plan:
- portid=0, ptr[5]=3, request sid 5, both readies high -> next cycle: o_addr_v=1, ptr=3, o_req_v=1<<5, o_rd_act=1; retires in 1 cycle; back-to-back requests retire every cycle.
- portid=2, i_rd_acts=0b11, i_rd_sids={5,5}, ptr[5]=6 -> o_addr_ptr=8. With ptr[5]=15 (ptr_width=4) -> wraps to 1.
- i_l1_end[7]=1, request sid 7 -> o_addr_v=1, o_addr_discard=1, o_req_v=0, o_rd_act=0, o_disc_cnt 0->1.
- i_rst_end[3]=i_single_v[3]=1, ptr[3]=7, portid=1 with one hit on sid 3 -> ptr_calc=8, bit[3]=1 -> discard. Same setup with no hit -> normal read.
- o_addr_r=1, o_req_r=0 for 3 cycles, i_l1_end rising meanwhile -> o_addr_v fires once, the update stays pending with disc=0, retires when o_req_r=1, and i_rd_r stays 0 until then.
- Assert reset mid-transaction -> s1_v=0, o_req_v=0, counter=0; after release, a fresh request behaves normally. Force cnt_width=2 and discard 5 times -> o_disc_cnt=3.
